wb_rr_arbiter: RTL

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter_pkg.sv | 13 +
 rtl/wb_rr_arbiter_if.sv | 34 +++
 rtl/wb_rr_prio.sv | 23 ++
 rtl/wb_rr_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// rtl/wb_rr_arbiter_pkg.sv - shared types and constants for the Wishbone round-robin arbiter
package wb_rr_arbiter_pkg;

    localparam int MAX_MASTERS  = 4;
    localparam int WB_TAG_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - Wishbone B4 bus interface with master/slave modports
interface wb_if
    import wb_rr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = WB_TAG_WIDTH
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [TAG_WIDTH-1:0]    tga;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [TAG_WIDTH-1:0]    tgd_w;
    logic                    cyc;
    logic [TAG_WIDTH-1:0]    tgc;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    stb;
    logic                    we;
    logic                    ack;
    logic                    err;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [TAG_WIDTH-1:0]    tgd_r;

    modport master (
        output adr, tga, cti, bte, dat_w, tgd_w, cyc, tgc, sel, stb, we,
        input  ack, err, dat_r, tgd_r
    );

    modport slave (
        input  adr, tga, cti, bte, dat_w, tgd_w, cyc, tgc, sel, stb, we,
        output ack, err, dat_r, tgd_r
    );
endinterface

// File: rtl/wb_rr_prio.sv
// rtl/wb_rr_prio.sv - rotating-priority encoder: first requester after 'last', wrapping
module wb_rr_prio
    import wb_rr_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       valid
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = last;
        valid   = 1'b0;
        for (int k = MAX_MASTERS; k >= 1; k--) begin
            if (req[last + 2'(k)]) begin
                gnt_idx = last + 2'(k);
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter, up to four requesters onto one slave
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int N_MASTERS     = 4,
    parameter int TIMEOUT       = 256
) (
    input  logic  clk,
    input  logic  rstn,
    wb_if.slave   m0,
    wb_if.slave   m1,
    wb_if.slave   m2,
    wb_if.slave   m3,
    wb_if.master  s
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0]   adr;
        logic [WB_TAG_WIDTH-1:0]    tga;
        logic [2:0]                 cti;
        logic [1:0]                 bte;
        logic [WB_DATA_WIDTH-1:0]   dat_w;
        logic [WB_TAG_WIDTH-1:0]    tgd_w;
        logic                       cyc;
        logic [WB_TAG_WIDTH-1:0]    tgc;
        logic [WB_DATA_WIDTH/8-1:0] sel;
        logic                       stb;
        logic                       we;
    } wb_req_t;

    arb_state_t      state, state_nxt;
    logic [1:0]      grant, last_grant;
    logic [WD_W-1:0] wd_cnt;
    wb_req_t         req [MAX_MASTERS];
    wb_req_t         req_out;
    logic [3:0]      cyc_vec;
    logic [1:0]      prio_idx;
    logic            prio_valid;
    logic            grant_cyc;
    logic [3:0]      m_ack, m_err;

    assign req[0] = {m0.adr, m0.tga, m0.cti, m0.bte, m0.dat_w, m0.tgd_w,
                     m0.cyc, m0.tgc, m0.sel, m0.stb, m0.we};
    assign req[1] = {m1.adr, m1.tga, m1.cti, m1.bte, m1.dat_w, m1.tgd_w,
                     m1.cyc, m1.tgc, m1.sel, m1.stb, m1.we};
    assign req[2] = {m2.adr, m2.tga, m2.cti, m2.bte, m2.dat_w, m2.tgd_w,
                     m2.cyc, m2.tgc, m2.sel, m2.stb, m2.we};
    assign req[3] = {m3.adr, m3.tga, m3.cti, m3.bte, m3.dat_w, m3.tgd_w,
                     m3.cyc, m3.tgc, m3.sel, m3.stb, m3.we};

    // Ports beyond N_MASTERS can never request, so they can never be granted.
    always_comb begin
        cyc_vec = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            cyc_vec[i] = req[i].cyc && (i < N_MASTERS);
        end
    end

    assign grant_cyc = req[grant].cyc;

    wb_rr_prio u_prio (
        .req     (cyc_vec),
        .last    (last_grant),
        .gnt_idx (prio_idx),
        .valid   (prio_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 2'(N_MASTERS - 1);
            wd_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && prio_valid) begin
                grant <= prio_idx;
            end
            if ((state == GRANT && !grant_cyc) || state == ABORT) begin
                last_grant <= grant;
            end
            if (state != GRANT) begin
                wd_cnt <= '0;
            end else if (s.ack || s.err) begin
                wd_cnt <= '0;
            end else if (s.stb && wd_cnt < WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (prio_valid) state_nxt = GRANT;
            end
            GRANT: begin
                if (!grant_cyc) begin
                    state_nxt = IDLE;
                end else if (TIMEOUT > 0 && wd_cnt == WD_MAX) begin
                    state_nxt = ABORT;
                end
            end
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Downstream sees the granted requester only during GRANT; ABORT and IDLE park the bus.
    always_comb begin
        req_out = '0;
        m_ack   = '0;
        m_err   = '0;
        if (state == GRANT) begin
            req_out = req[grant];
        end
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (i < N_MASTERS && grant == 2'(i)) begin
                if (state == GRANT) begin
                    m_ack[i] = s.ack;
                    m_err[i] = s.err;
                end else if (state == ABORT) begin
                    m_err[i] = 1'b1;
                end
            end
        end
    end

    assign s.adr   = req_out.adr;
    assign s.tga   = req_out.tga;
    assign s.cti   = req_out.cti;
    assign s.bte   = req_out.bte;
    assign s.dat_w = req_out.dat_w;
    assign s.tgd_w = req_out.tgd_w;
    assign s.cyc   = req_out.cyc;
    assign s.tgc   = req_out.tgc;
    assign s.sel   = req_out.sel;
    assign s.stb   = req_out.stb;
    assign s.we    = req_out.we;

    assign m0.ack = m_ack[0];
    assign m1.ack = m_ack[1];
    assign m2.ack = m_ack[2];
    assign m3.ack = m_ack[3];
    assign m0.err = m_err[0];
    assign m1.err = m_err[1];
    assign m2.err = m_err[2];
    assign m3.err = m_err[3];

    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m2.dat_r = s.dat_r;
    assign m3.dat_r = s.dat_r;
    assign m0.tgd_r = s.tgd_r;
    assign m1.tgd_r = s.tgd_r;
    assign m2.tgd_r = s.tgd_r;
    assign m3.tgd_r = s.tgd_r;

endmodule
